// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter and the divider it drives:
// controller state encoding and the 2-bit response error codes.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KICK = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } div_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches the request vector starting at ptr and returns
// the first asserted requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NUM_REQ requesters with round-robin
// arbitration, a one-entry result cache and a WAIT-state timeout.
module div_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ-1:0]           req_unsigned_i,
  input  logic [NUM_REQ-1:0]           req_out_type_i,
  input  logic [NUM_REQ*WIDTH-1:0]     req_n_i,
  input  logic [NUM_REQ*WIDTH-1:0]     req_d_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [WIDTH-1:0]             rsp_data_o,
  output logic [1:0]                   rsp_error_o,
  output logic                         div_rst_o,
  output logic                         div_valid_o,
  output logic                         div_unsigned_o,
  output logic                         div_out_type_o,
  output logic [WIDTH-1:0]             div_n_o,
  output logic [WIDTH-1:0]             div_d_o,
  input  logic                         div_ready_i,
  input  logic [WIDTH-1:0]             div_q_i,
  input  logic [WIDTH-1:0]             div_r_i,
  input  logic [1:0]                   div_error_i
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  div_state_e state, state_nxt;

  logic               init_q;
  logic               quiet;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic               grant_fire;
  logic               cache_hit;
  logic               timed_out;

  logic [WIDTH-1:0]   sel_n, sel_d;
  logic               sel_uns, sel_ot;

  logic [IDW-1:0]     lat_id;
  logic [WIDTH-1:0]   lat_n, lat_d;
  logic               lat_uns, lat_ot;
  logic [WIDTH-1:0]   res_q, res_r;
  logic [1:0]         res_err;

  logic               cache_valid;
  logic [WIDTH-1:0]   cache_n, cache_d, cache_q, cache_r;
  logic               cache_uns;
  logic [1:0]         cache_err;

  logic [CW-1:0]      wait_cnt;

  // The reset cycle and the one right after it are kept silent: no grants,
  // no responses, divider held in reset.
  assign quiet = rst_i | init_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req_valid_i),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_any)
  );

  assign grant_fire  = (state == IDLE) && !quiet && grant_any;
  assign req_ready_o = grant_fire ? grant : '0;

  assign sel_n   = req_n_i[grant_idx*WIDTH +: WIDTH];
  assign sel_d   = req_d_i[grant_idx*WIDTH +: WIDTH];
  assign sel_uns = req_unsigned_i[grant_idx];
  assign sel_ot  = req_out_type_i[grant_idx];

  assign cache_hit = cache_valid && (sel_n == cache_n) && (sel_d == cache_d)
                     && (sel_uns == cache_uns);
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

  assign div_n_o        = lat_n;
  assign div_d_o        = lat_d;
  assign div_unsigned_o = lat_uns;
  assign div_out_type_o = lat_ot;

  always_comb begin
    state_nxt   = state;
    rsp_valid_o = 1'b0;
    rsp_id_o    = '0;
    rsp_data_o  = '0;
    rsp_error_o = ERR_OK;
    div_valid_o = 1'b0;
    div_rst_o   = quiet;
    case (state)
      IDLE: if (grant_fire) state_nxt = cache_hit ? RESP : LOAD;
      LOAD: begin
        div_rst_o = 1'b1;
        state_nxt = KICK;
      end
      KICK: begin
        div_valid_o = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: if (div_ready_i || timed_out) state_nxt = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_id_o    = lat_id;
        rsp_data_o  = lat_ot ? res_q : res_r;
        rsp_error_o = res_err;
        if (rsp_ready_i) begin
          div_rst_o = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst_i) begin
      rsp_valid_o = 1'b0;
      rsp_id_o    = '0;
      rsp_data_o  = '0;
      rsp_error_o = ERR_OK;
      div_valid_o = 1'b0;
      div_rst_o   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      init_q      <= 1'b1;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      lat_id      <= '0;
      lat_n       <= '0;
      lat_d       <= '0;
      lat_uns     <= 1'b0;
      lat_ot      <= 1'b0;
      res_q       <= '0;
      res_r       <= '0;
      res_err     <= ERR_OK;
      cache_valid <= 1'b0;
      cache_n     <= '0;
      cache_d     <= '0;
      cache_uns   <= 1'b0;
      cache_q     <= '0;
      cache_r     <= '0;
      cache_err   <= ERR_OK;
    end else begin
      init_q <= 1'b0;
      state  <= state_nxt;
      if (grant_fire) begin
        lat_id  <= grant_idx;
        lat_n   <= sel_n;
        lat_d   <= sel_d;
        lat_uns <= sel_uns;
        lat_ot  <= sel_ot;
        rr_ptr  <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        if (cache_hit) begin
          res_q   <= cache_q;
          res_r   <= cache_r;
          res_err <= cache_err;
        end
      end
      if (state == KICK) wait_cnt <= '0;
      // A timed-out result is reported as zero and never enters the cache.
      if (state == WAIT) begin
        if (div_ready_i) begin
          res_q       <= div_q_i;
          res_r       <= div_r_i;
          res_err     <= div_error_i;
          cache_valid <= 1'b1;
          cache_n     <= lat_n;
          cache_d     <= lat_d;
          cache_uns   <= lat_uns;
          cache_q     <= div_q_i;
          cache_r     <= div_r_i;
          cache_err   <= div_error_i;
        end else if (timed_out) begin
          res_q   <= '0;
          res_r   <= '0;
          res_err <= ERR_TIMEOUT;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule
